// File: rtl/regfile_pkg.sv
// Shared definitions for the 4x16 register file write-back path.
package regfile_pkg;
  localparam int DATA_W     = 16;
  localparam int REG_IDX_W  = 2;
  localparam int NUM_REGS   = 1 << REG_IDX_W;
  localparam int FIFO_DEPTH = 4;
  localparam int COUNT_W    = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [REG_IDX_W-1:0] idx;
    logic [DATA_W-1:0]    data;
  } wb_entry_t;

  localparam int ENTRY_W = $bits(wb_entry_t);
endpackage

// File: rtl/regfile_writeback_queue_fifo.sv
// In-order synchronous FIFO that also exposes every slot and its occupancy,
// so the owner can scan queued entries without popping them.
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 18,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic                   full,
  output logic                   empty,
  output logic [PTR_W:0]         count,
  output logic [DEPTH-1:0]       entry_valid,
  output logic [DEPTH*WIDTH-1:0] entries
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full      = (count_q == (PTR_W+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  // Pushing while full is dropped even if a pop frees a slot the same cycle.
  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    mem_d   = mem_q;
    if (do_push) mem_d[wr_ptr_q] = push_data;
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // A slot is live when its distance from the read pointer is below the count.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    logic [PTR_W-1:0] offset;
    assign offset                      = PTR_W'(gi) - rd_ptr_q;
    assign entry_valid[gi]             = ({1'b0, offset} < count_q);
    assign entries[gi*WIDTH +: WIDTH]  = mem_q[gi];
  end
endmodule

// File: rtl/regfile_writeback_queue.sv
// Write-side master for the register file: arbitrates ALU/multiplier results,
// queues them in order and drains one per cycle onto the single write port.
module regfile_writeback_queue
  import regfile_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mul_valid,
  output logic                 mul_ready,
  input  logic [REG_IDX_W-1:0] mul_reg_index,
  input  logic [DATA_W-1:0]    mul_data,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [REG_IDX_W-1:0] alu_reg_index,
  input  logic [DATA_W-1:0]    alu_data,
  output logic                 write_enable,
  output logic [REG_IDX_W-1:0] write_reg_index,
  output logic [DATA_W-1:0]    write_data,
  output logic [NUM_REGS-1:0]  pending_mask,
  output logic [COUNT_W-1:0]   fifo_count
);
  logic                          push;
  logic                          full;
  logic                          empty;
  wb_entry_t                     push_entry;
  wb_entry_t                     head_entry;
  logic [FIFO_DEPTH-1:0]         entry_valid;
  logic [FIFO_DEPTH*ENTRY_W-1:0] entries;
  wb_entry_t                     entry_arr [FIFO_DEPTH];

  logic                 write_enable_q, write_enable_d;
  logic [REG_IDX_W-1:0] write_reg_index_q, write_reg_index_d;
  logic [DATA_W-1:0]    write_data_q, write_data_d;

  // Multiplier has fixed priority; the ALU only sees ready when the multiplier is idle.
  assign mul_ready = !full;
  assign alu_ready = !full && !mul_valid;

  always_comb begin
    push = (mul_valid && mul_ready) || (alu_valid && alu_ready);
    if (mul_valid) begin
      push_entry.idx  = mul_reg_index;
      push_entry.data = mul_data;
    end else begin
      push_entry.idx  = alu_reg_index;
      push_entry.data = alu_data;
    end
  end

  wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .push_data   (push_entry),
    .pop         (!empty),
    .head_data   (head_entry),
    .full        (full),
    .empty       (empty),
    .count       (fifo_count),
    .entry_valid (entry_valid),
    .entries     (entries)
  );

  // Index/data hold their last value when the queue is empty.
  always_comb begin
    write_enable_d    = !empty;
    write_reg_index_d = write_reg_index_q;
    write_data_d      = write_data_q;
    if (!empty) begin
      write_reg_index_d = head_entry.idx;
      write_data_d      = head_entry.data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_enable_q    <= 1'b0;
      write_reg_index_q <= '0;
      write_data_q      <= '0;
    end else begin
      write_enable_q    <= write_enable_d;
      write_reg_index_q <= write_reg_index_d;
      write_data_q      <= write_data_d;
    end
  end

  assign write_enable    = write_enable_q;
  assign write_reg_index = write_reg_index_q;
  assign write_data      = write_data_q;

  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_unpack
    assign entry_arr[gi] = entries[gi*ENTRY_W +: ENTRY_W];
  end

  // A register stays pending while queued or while its write is on the port.
  always_comb begin
    pending_mask = '0;
    if (write_enable_q) pending_mask[write_reg_index_q] = 1'b1;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (entry_valid[i]) pending_mask[entry_arr[i].idx] = 1'b1;
    end
  end
endmodule
